// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one sprite ROM read port between four requesters. Each cycle at
// most one requester is granted (round-robin, starting after the last
// winner). The granted address is registered onto rom_addr, and a 2-bit
// requester tag follows the grant down a ROM_LATENCY-deep valid/tag
// pipeline. When the tag reaches the end, rom_data is registered into
// rd_data and the matching rd_valid bit is raised for one cycle.
//
// Parameters
//   ADDR_W       sprite ROM address width
//   DATA_W       ROM pixel width ({R[2:0],G[2:0],B[1:0]} at 8 bits)
//   ROM_LATENCY  cycles from rom_addr to valid rom_data (1 or 2)
//
// Ports
//   clk                  sole clock, rising edge
//   rst                  synchronous active-high reset
//   en                   allows new grants when high
//   req[3:0]             per-requester read request
//   addr0..addr3         per-requester read address
//   gnt[3:0]             one-hot/zero, one cycle per grant
//   rom_addr             registered address to the ROM
//   rom_data             ROM read data, ROM_LATENCY cycles after rom_addr
//   rd_data              registered read data back to the requesters
//   rd_valid[3:0]        one-hot/zero owner of rd_data this cycle
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic [3:0]        gnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        rd_valid
);

  // Round-robin search starting at last+1. Iterating from the farthest
  // candidate down to the nearest lets the nearest requesting index win.
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] tag);
    return 4'b0001 << tag;
  endfunction

  logic [1:0]        last_granted;
  logic [2:0]        pick_c;
  logic [ADDR_W-1:0] sel_addr;

  logic              vld_p0;
  logic [1:0]        tag_p0;
  logic              vld_p1;
  logic [1:0]        tag_p1;

  logic              ret_vld;
  logic [1:0]        ret_tag;

  always_comb begin
    pick_c = rr_pick(req, last_granted);
  end

  always_comb begin
    sel_addr = addr0;
    case (pick_c[1:0])
      2'd0:    sel_addr = addr0;
      2'd1:    sel_addr = addr1;
      2'd2:    sel_addr = addr2;
      default: sel_addr = addr3;
    endcase
  end

  // ---- stage p0: grant selection -> gnt / rom_addr (gnt cycle) ----------
  // rom_addr and last_granted only move on a real grant, so an idle or
  // disabled edge leaves both untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      tag_p0       <= 2'd0;
      rom_addr     <= '0;
      last_granted <= 2'd3;
    end else if (en && pick_c[2]) begin
      vld_p0       <= 1'b1;
      tag_p0       <= pick_c[1:0];
      rom_addr     <= sel_addr;
      last_granted <= pick_c[1:0];
    end else begin
      vld_p0       <= 1'b0;
    end
  end

  assign gnt = vld_p0 ? onehot(tag_p0) : 4'b0000;

  // ---- stage p1: first ROM latency cycle ---------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      tag_p1 <= 2'd0;
    end else begin
      vld_p1 <= vld_p0;
      tag_p1 <= tag_p0;
    end
  end

  // ---- stage p2: second ROM latency cycle (ROM_LATENCY == 2 only) --------
  // Any value other than 2 is built as a single-cycle ROM.
  generate
    if (ROM_LATENCY == 2) begin : g_lat2
      logic       vld_p2;
      logic [1:0] tag_p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2 <= 1'b0;
          tag_p2 <= 2'd0;
        end else begin
          vld_p2 <= vld_p1;
          tag_p2 <= tag_p1;
        end
      end

      assign ret_vld = vld_p2;
      assign ret_tag = tag_p2;
    end else begin : g_lat1
      assign ret_vld = vld_p1;
      assign ret_tag = tag_p1;
    end
  endgenerate

  // ---- return stage: capture rom_data for the tagged requester -----------
  // rd_data holds between returns; rd_valid is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 4'b0000;
    end else if (ret_vld) begin
      rd_data  <= rom_data;
      rd_valid <= onehot(ret_tag);
    end else begin
      rd_valid <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Drives two instances of sprite_rom_arbiter (ROM_LATENCY 1 and 2) from the
// same stimulus, each attached to its own ROM model. A queue-based reference
// model predicts gnt / rom_addr per edge and schedules every return as an
// event due at grant edge + ROM_LATENCY + 1.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic [3:0]    req;
  logic [AW-1:0] addr_v [4];

  logic [3:0]    gnt1, gnt2, rv1, rv2;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rdat1, rdat2, rom1, rom2, rom2_a;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;

  // ROM contents: fixed value at 0x0100, a simple hash elsewhere.
  function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
    if (a == 15'h0100) return 8'hE3;
    return a[7:0] ^ {a[14:8], 1'b0} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    rom1   <= rom_f(ra1);
    rom2_a <= rom_f(ra2);
    rom2   <= rom2_a;
  end

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .addr0(addr_v[0]), .addr1(addr_v[1]), .addr2(addr_v[2]), .addr3(addr_v[3]),
    .gnt(gnt1), .rom_addr(ra1), .rom_data(rom1), .rd_data(rdat1), .rd_valid(rv1)
  );

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .addr0(addr_v[0]), .addr1(addr_v[1]), .addr2(addr_v[2]), .addr3(addr_v[3]),
    .gnt(gnt2), .rom_addr(ra2), .rom_data(rom2), .rd_data(rdat2), .rd_valid(rv2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [1:0] tag;
    logic [7:0] data;
  } ret_t;

  ret_t          q1 [$];
  ret_t          q2 [$];
  logic [3:0]    m_gnt, m_rv1, m_rv2;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_last;
  logic [DW-1:0] m_rd1, m_rd2;

  task automatic model_edge();
    int w;
    bit found;
    edge_no++;
    if (rst) begin
      m_gnt = 0; m_addr = 0; m_last = 2'd3;
      m_rv1 = 0; m_rv2 = 0; m_rd1 = 0; m_rd2 = 0;
      q1.delete(); q2.delete();
    end else begin
      m_rv1 = 0;
      if (q1.size() > 0 && q1[0].due == edge_no) begin
        m_rv1 = 4'b0001 << q1[0].tag; m_rd1 = q1[0].data; void'(q1.pop_front());
      end
      m_rv2 = 0;
      if (q2.size() > 0 && q2[0].due == edge_no) begin
        m_rv2 = 4'b0001 << q2[0].tag; m_rd2 = q2[0].data; void'(q2.pop_front());
      end
      m_gnt = 0; found = 0; w = 0;
      if (en && req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && req[(int'(m_last) + k) % 4]) begin
            found = 1; w = (int'(m_last) + k) % 4;
          end
        end
      end
      if (found) begin
        m_gnt  = 4'b0001 << w;
        m_addr = addr_v[w];
        m_last = 2'(w);
        q1.push_back('{edge_no + 2, 2'(w), rom_f(addr_v[w])});
        q2.push_back('{edge_no + 3, 2'(w), rom_f(addr_v[w])});
      end
    end
  endtask

  function automatic logic [61:0] vec_dut();
    return {gnt1, gnt2, ra1, ra2, rv1, rv2, rdat1, rdat2};
  endfunction

  function automatic logic [61:0] vec_model();
    return {m_gnt, m_gnt, m_addr, m_addr, m_rv1, m_rv2, m_rd1, m_rd2};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'hF;
    for (int i = 0; i < 4; i++) addr_v[i] = 15'(16'h0200 + i);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL reset_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      if ({gnt1, gnt2, rv1, rv2, ra1, rdat1, rdat2} !== '0) begin
        n_bad++; $display("FAIL reset_state edge=%0d got %h required 0", edge_no,
                          {gnt1, gnt2, rv1, rv2, ra1, rdat1, rdat2});
      end
      n_cmp++;
    end
    rst = 1'b0;
    tick();
    if (gnt1 !== 4'b0001 || ra1 !== 15'h0200) begin
      n_bad++; $display("FAIL reset_first_grant gnt=%b addr=%h required 0001/0200", gnt1, ra1);
    end
    n_cmp++;
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL reset_drain edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; en = 1'b1; addr_v[0] = 15'h0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      req = 4'b0000;
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL single_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      case (i)
        0: begin
          if (gnt1 !== 4'b0001 || ra1 !== 15'h0100) begin
            n_bad++; $display("FAIL single_gnt gnt=%b addr=%h required 0001/0100", gnt1, ra1);
          end
          n_cmp++;
        end
        2: begin
          if (rv1 !== 4'b0001 || rdat1 !== 8'hE3 || rv2 !== 4'b0000) begin
            n_bad++; $display("FAIL single_ret_l1 rv1=%b data=%h rv2=%b required 0001/e3/0000", rv1, rdat1, rv2);
          end
          n_cmp++;
        end
        3: begin
          if (rv2 !== 4'b0001 || rdat2 !== 8'hE3 || rv1 !== 4'b0000) begin
            n_bad++; $display("FAIL single_ret_l2 rv2=%b data=%h rv1=%b required 0001/e3/0000", rv2, rdat2, rv1);
          end
          n_cmp++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_contention();
    apply_reset();
    en = 1'b1; req = 4'hF;
    for (int i = 0; i < 4; i++) addr_v[i] = 15'(16'h0010 + i);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL cont_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      if (gnt1 !== (4'b0001 << (i % 4)) || ra1 !== 15'(16'h0010 + i % 4)) begin
        n_bad++; $display("FAIL cont_gnt step=%0d gnt=%b addr=%h required %b/%h", i, gnt1, ra1,
                          4'b0001 << (i % 4), 16'h0010 + i % 4);
      end
      n_cmp++;
      if (i >= 2 && (rv1 !== (4'b0001 << ((i - 2) % 4)) || rdat1 !== rom_f(15'(16'h0010 + (i - 2) % 4)))) begin
        n_bad++; $display("FAIL cont_ret step=%0d rv1=%b data=%h required %b/%h", i, rv1, rdat1,
                          4'b0001 << ((i - 2) % 4), rom_f(15'(16'h0010 + (i - 2) % 4)));
      end
      if (i >= 2) n_cmp++;
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL cont_drain edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
    apply_reset();
    en = 1'b1; req = 4'b0001;
    addr_v[0] = 15'h0A00; addr_v[2] = 15'h0A02;
    for (int i = 0; i < 4; i++) begin
      tick();
      req = 4'b0101;
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL rot_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      if (gnt2 !== exp_g[i]) begin
        n_bad++; $display("FAIL rot_gnt step=%0d gnt=%b required %b", i, gnt2, exp_g[i]);
      end
      n_cmp++;
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b1; req = 4'b0001; addr_v[0] = 15'h0ABC;
    addr_v[1] = 15'h1234; addr_v[3] = 15'h0777;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0; req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL en_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      if ({gnt1, gnt2, rv1, rv2} !== 16'h0 || ra1 !== 15'h0ABC || ra2 !== 15'h0ABC) begin
        n_bad++; $display("FAIL en_gated step=%0d gnt=%b/%b rv=%b/%b addr=%h required 0/0/0/0/0abc",
                          i, gnt1, gnt2, rv1, rv2, ra1);
      end
      n_cmp++;
    end
    en = 1'b1;
    tick();
    if (gnt1 !== 4'b0010 || ra1 !== 15'h1234) begin
      n_bad++; $display("FAIL en_rise gnt=%b addr=%h required 0010/1234", gnt1, ra1);
    end
    n_cmp++;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    en = 1'b1; req = 4'b0100; addr_v[2] = 15'h0222; addr_v[0] = 15'h0333;
    tick();
    if (gnt2 !== 4'b0100) begin
      n_bad++; $display("FAIL mid_gnt gnt=%b required 0100", gnt2);
    end
    n_cmp++;
    req = 4'b0000; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rv1 !== 4'b0000 || rv2 !== 4'b0000) begin
        n_bad++; $display("FAIL mid_no_ret step=%0d rv=%b/%b required 0000", i, rv1, rv2);
      end
      n_cmp++;
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL mid_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
    end
    req = 4'b0101;
    tick();
    req = 4'b0000;
    if (gnt2 !== 4'b0001 || ra2 !== 15'h0333) begin
      n_bad++; $display("FAIL mid_regrant gnt=%b addr=%h required 0001/0333", gnt2, ra2);
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rv;
    apply_reset();
    en = 1'b1; req = 4'b0011;
    addr_v[0] = 15'h0155; addr_v[1] = 15'h02AA;
    for (int t = 0; t < 16; t++) begin
      if (t == 12) req = 4'b0000;
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL b2b_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      exp_rv = (t >= 3 && t - 3 < 12) ? (4'b0001 << ((t - 3) % 2)) : 4'b0000;
      if (rv2 !== exp_rv || (exp_rv != 4'b0000 && rdat2 !== rom_f(addr_v[(t - 3) % 2]))) begin
        n_bad++; $display("FAIL b2b_ret t=%0d rv2=%b data=%h required %b/%h", t, rv2, rdat2, exp_rv,
                          (t >= 3) ? rom_f(addr_v[(t - 3) % 2]) : 8'h00);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 7) != 0);
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) addr_v[i] = 15'($urandom);
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL rand_full edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
      if (!($onehot0(gnt1) && $onehot0(gnt2) && $onehot0(rv1) && $onehot0(rv2))) begin
        n_bad++; $display("FAIL rand_onehot edge=%0d gnt=%b/%b rv=%b/%b required one-hot or zero",
                          edge_no, gnt1, gnt2, rv1, rv2);
      end
      n_cmp++;
    end
    rst = 1'b0; req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vec_dut() !== vec_model()) begin
        n_bad++; $display("FAIL rand_drain edge=%0d dut=%h model=%h", edge_no, vec_dut(), vec_model());
      end
      n_cmp++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    for (int i = 0; i < 4; i++) addr_v[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_enable();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
